mem_loader: RTL and testbench
=============================

Name: mem_loader

Overview:
- Host-side initiator for the processor's external memory-load ports.
- Accepts a valid/ready command stream and turns it into strobed writes and reads on the instruction-memory external port (32-bit) and the data-memory external port (64-bit).
- Returns read data on a valid/ready response stream.
- Owns the processor `enable` line: RUN asserts it, STOP releases it.

Parameters:
- RD_LAT, 1: SRAM external-port read latency in cycles, from the ren cycle to rdata valid; legal range 1..4.
- DROP_W, 8: width of the saturating dropped-command counter.

Ports:
- clk  in  1  main clock
- arst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command ready
- cmd_op  in  3  0 WR_IMEM, 1 WR_DMEM, 2 RD_IMEM, 3 RD_DMEM, 4 RUN, 5 STOP, 6-7 illegal
- cmd_addr  in  64  byte address
- cmd_wdata  in  64  write data; WR_IMEM uses [31:0]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_data  out  64  read data; RD_IMEM is zero-extended
- addr_ext  out  64  imem external address
- wen_ext  out  1  imem write strobe
- ren_ext  out  1  imem read strobe
- wdata_ext  out  32  imem write word
- rdata_ext  in  32  imem read word
- addr_ext_2  out  64  dmem external address
- wen_ext_2  out  1  dmem write strobe
- ren_ext_2  out  1  dmem read strobe
- wdata_ext_2  out  64  dmem write word
- rdata_ext_2  in  64  dmem read word
- cpu_enable  out  1  processor run enable
- busy  out  1  state is not IDLE and not RUN
- drop_cnt  out  DROP_W  saturating count of discarded commands
- checksum  out  64  see Optional Feature

Behaviour:
- Reset values: all outputs are registered and reset to 0, except cmd_ready.
  - cmd_ready is combinational: 1 in IDLE and RUN, else 0.
  - State resets to IDLE.
- A transfer occurs when cmd_valid && cmd_ready on a rising edge. The op, address and data are captured into registers.
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP, RUN.
- IDLE, accept WR_*:
  - Go to WRITE.
  - Next cycle: the selected wen strobe is high for exactly one cycle, with addr and wdata held from registers. The other port stays idle.
  - Then return to IDLE. Throughput is 1 write per 2 cycles.
- IDLE, accept RD_*:
  - RD_ISSUE: ren of the selected port high for exactly one cycle, addr driven.
  - RD_WAIT: count RD_LAT cycles starting from the ren cycle. rdata is sampled on the edge ending cycle RD_LAT after ren and captured into rsp_data.
  - RESP: rsp_valid=1, rsp_data held stable until rsp_ready; the handshake cycle returns to IDLE.
  - With RD_LAT=1, rsp_valid rises 2 cycles after acceptance.
- IDLE, accept RUN: cpu_enable=1 from the next cycle; go to RUN.
- RUN:
  - All ext strobes are 0; cmd_ready=1.
  - STOP: cpu_enable=0 next cycle; go to IDLE.
  - Any other op: accepted, discarded, drop_cnt++.
- IDLE, accept STOP: no-op.
- Alignment and legality. The following are accepted, discarded, increment drop_cnt, and leave state at IDLE with no strobe:
  - WR_IMEM/RD_IMEM with cmd_addr[1:0] != 0.
  - WR_DMEM/RD_DMEM with cmd_addr[2:0] != 0.
  - Illegal ops 6-7.
- drop_cnt saturates at all-ones and never wraps.
- Strobe rules:
  - wen_ext and ren_ext are never high together; likewise wen_ext_2 and ren_ext_2.
  - At most one port is active per cycle.
  - Strobes are never high while cpu_enable=1.
- Reset mid-operation: state goes immediately to IDLE; strobes, rsp_valid and cpu_enable drop asynchronously. Any pending response is lost.
- rsp_ready held high early has no effect outside RESP.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: checksum is a 64-bit wrapping sum of every performed write's data, zero-extended for imem. It updates in the WRITE cycle and clears on reset and on RUN acceptance.
- Undefined: checksum is tied to 0 and no accumulator logic is present.

Decomposition:
- Package loader_pkg holds:
  - op encodings (OP_WR_IMEM..OP_STOP);
  - the state enum;
  - alignment mask constants IMEM_ALIGN_MASK=2'b11 and DMEM_ALIGN_MASK=3'b111.
- One sub-module, loader_checksum (accumulator, instantiated under the macro). Everything else stays in mem_loader.

Test Plan:
- WR_IMEM addr=0x8 wdata=0x00A00093 -> one cycle later wen_ext=1, addr_ext=0x8, wdata_ext=0x00A00093 for exactly 1 cycle; busy=1 that cycle.
- WR_DMEM 0x10 <- 0xDEADBEEFCAFEF00D, then RD_DMEM 0x10 against an SRAM model with RD_LAT=1 -> rsp_valid 2 cycles after acceptance with rsp_data=0xDEADBEEFCAFEF00D. Hold rsp_ready=0 for 3 cycles -> data stable and cmd_ready=0 throughout.
- RD_IMEM addr=0x6 (misaligned) and op=7 -> no strobes, drop_cnt=2, state stays IDLE. With DROP_W=2, five drops -> drop_cnt saturates at 3.
- RUN -> cpu_enable=1 next cycle; WR_DMEM during RUN -> no wen_ext_2, drop_cnt++; STOP -> cpu_enable=0 next cycle; a subsequent write performs normally.
- Assert arst_n=0 during RD_WAIT (RD_LAT=3) -> ren/rsp_valid/cpu_enable 0 immediately, state IDLE after release, cmd_ready=1.
- LOADER_CHECKSUM_EN defined: writes 0xFFFFFFFF (imem) and 0xFFFFFFFFFFFFFFFF (dmem) -> checksum=0x00000000FFFFFFFE. Then RUN -> checksum=0.

Source files
------------

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared definitions for the memory loader: command opcodes,
//               controller state encoding, address alignment masks and the
//               command legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

  // Command opcodes carried on cmd_op; codes 6 and 7 are illegal.
  localparam logic [2:0] OP_WR_IMEM = 3'd0;
  localparam logic [2:0] OP_WR_DMEM = 3'd1;
  localparam logic [2:0] OP_RD_IMEM = 3'd2;
  localparam logic [2:0] OP_RD_DMEM = 3'd3;
  localparam logic [2:0] OP_RUN     = 3'd4;
  localparam logic [2:0] OP_STOP    = 3'd5;

  // Byte-address bits that must be zero for a word (imem) or doubleword (dmem).
  localparam logic [1:0] IMEM_ALIGN_MASK = 2'b11;
  localparam logic [2:0] DMEM_ALIGN_MASK = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RESP     = 3'd4,
    ST_RUN      = 3'd5
  } state_e;

  // True when a command accepted in IDLE is performed rather than dropped.
  // Only the low three address bits take part in the alignment test.
  function automatic logic cmd_is_legal(input logic [2:0] op,
                                        input logic [2:0] addr_lo);
    logic ok;
    case (op)
      OP_WR_IMEM, OP_RD_IMEM: ok = ((addr_lo[1:0] & IMEM_ALIGN_MASK) == 2'b00);
      OP_WR_DMEM, OP_RD_DMEM: ok = ((addr_lo & DMEM_ALIGN_MASK) == 3'b000);
      OP_RUN, OP_STOP:        ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/loader_checksum.sv
`default_nettype none
// ============================================================================
// Module      : loader_checksum
// Description : 64-bit wrapping accumulator of performed write data.
//               Clear has priority over add.
// Ports       : clk      - clock
//               arst_n   - asynchronous active-low reset
//               clr      - synchronous clear of the running sum
//               add_en   - add add_val into the sum on this edge
//               add_val  - value to accumulate (already zero-extended)
//               sum      - registered running sum
// Revision    : 1.0 - initial release
// ============================================================================
module loader_checksum (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        clr,
  input  logic        add_en,
  input  logic [63:0] add_val,
  output logic [63:0] sum
);

  logic [63:0] sum_q;
  logic [63:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = 64'd0;
    end else if (add_en) begin
      sum_d = sum_q + add_val;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sum_q <= 64'd0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader
// Description : Host-side initiator for the processor external memory-load
//               ports. Converts a valid/ready command stream into single-cycle
//               write/read strobes on the 32-bit imem port and the 64-bit dmem
//               port, returns read data on a valid/ready response stream, and
//               owns the processor run enable.
// Build macro : LOADER_CHECKSUM_EN - when defined, checksum carries a wrapping
//               sum of performed write data; otherwise it is tied to zero.
// Parameters  : RD_LAT  - SRAM read latency in cycles (1..4)
//               DROP_W  - width of the saturating dropped-command counter
// Ports       : clk, arst_n             - clock, async active-low reset
//               cmd_valid/ready/op/addr/wdata - command stream
//               rsp_valid/ready/data    - response stream
//               addr_ext, wen_ext, ren_ext, wdata_ext, rdata_ext       - imem
//               addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, rdata_ext_2 - dmem
//               cpu_enable              - processor run enable
//               busy                    - transfer in progress
//               drop_cnt                - count of discarded commands
//               checksum                - running write checksum
// Revision    : 1.0 - initial release
// ============================================================================
module mem_loader #(
  parameter int RD_LAT = 1,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [63:0]       cmd_addr,
  input  logic [63:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_data,
  output logic [63:0]       addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [31:0]       wdata_ext,
  input  logic [31:0]       rdata_ext,
  output logic [63:0]       addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [63:0]       wdata_ext_2,
  input  logic [63:0]       rdata_ext_2,
  output logic              cpu_enable,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [63:0]       checksum
);

  import loader_pkg::*;

  localparam int                 CNT_W    = 3;
  localparam logic [CNT_W-1:0]   LAT_LAST = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [DROP_W-1:0]  DROP_ONE = DROP_W'(1);
  localparam logic [DROP_W-1:0]  DROP_MAX = {DROP_W{1'b1}};

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [63:0]       addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              wen_imem_q, wen_imem_d;
  logic              ren_imem_q, ren_imem_d;
  logic              wen_dmem_q, wen_dmem_d;
  logic              ren_dmem_q, ren_dmem_d;
  logic              cpu_enable_q, cpu_enable_d;
  logic              busy_q, busy_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic              xfer;
  logic              drop_inc;

  // Commands are only taken while nothing is in flight.
  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign xfer      = cmd_valid && cmd_ready;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_valid_d  = rsp_valid_q;
    cpu_enable_d = cpu_enable_q;
    // Strobes default low so every assertion below is a one-cycle pulse.
    wen_imem_d   = 1'b0;
    ren_imem_d   = 1'b0;
    wen_dmem_d   = 1'b0;
    ren_dmem_d   = 1'b0;
    drop_inc     = 1'b0;

    if (xfer) begin
      op_d    = cmd_op;
      addr_d  = cmd_addr;
      wdata_d = cmd_wdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (!cmd_is_legal(cmd_op, cmd_addr[2:0])) begin
            drop_inc = 1'b1;
          end else begin
            case (cmd_op)
              OP_WR_IMEM: begin
                state_d    = ST_WRITE;
                wen_imem_d = 1'b1;
              end
              OP_WR_DMEM: begin
                state_d    = ST_WRITE;
                wen_dmem_d = 1'b1;
              end
              OP_RD_IMEM: begin
                state_d    = ST_RD_ISSUE;
                ren_imem_d = 1'b1;
              end
              OP_RD_DMEM: begin
                state_d    = ST_RD_ISSUE;
                ren_dmem_d = 1'b1;
              end
              OP_RUN: begin
                state_d      = ST_RUN;
                cpu_enable_d = 1'b1;
              end
              default: begin
                // STOP while idle has nothing to release.
              end
            endcase
          end
        end
      end

      ST_WRITE: begin
        state_d = ST_IDLE;
      end

      ST_RD_ISSUE: begin
        // The ren cycle is the first latency cycle; RD_WAIT covers the rest
        // and samples on the edge that ends cycle RD_LAT after ren.
        state_d = ST_RD_WAIT;
        cnt_d   = CNT_ONE;
      end

      ST_RD_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          rsp_data_d  = (op_q == OP_RD_IMEM) ? {32'd0, rdata_ext} : rdata_ext_2;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (xfer) begin
          if (cmd_op == OP_STOP) begin
            state_d      = ST_IDLE;
            cpu_enable_d = 1'b0;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    drop_cnt_d = drop_cnt_q;
    if (drop_inc && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + DROP_ONE;
    end

    // Registered so busy tracks the state register with no decode glitch.
    busy_d = (state_d != ST_IDLE) && (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= 3'd0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      cnt_q        <= '0;
      rsp_data_q   <= 64'd0;
      rsp_valid_q  <= 1'b0;
      wen_imem_q   <= 1'b0;
      ren_imem_q   <= 1'b0;
      wen_dmem_q   <= 1'b0;
      ren_dmem_q   <= 1'b0;
      cpu_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_valid_q  <= rsp_valid_d;
      wen_imem_q   <= wen_imem_d;
      ren_imem_q   <= ren_imem_d;
      wen_dmem_q   <= wen_dmem_d;
      ren_dmem_q   <= ren_dmem_d;
      cpu_enable_q <= cpu_enable_d;
      busy_q       <= busy_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign addr_ext    = addr_q;
  assign wen_ext     = wen_imem_q;
  assign ren_ext     = ren_imem_q;
  assign wdata_ext   = wdata_q[31:0];
  assign addr_ext_2  = addr_q;
  assign wen_ext_2   = wen_dmem_q;
  assign ren_ext_2   = ren_dmem_q;
  assign wdata_ext_2 = wdata_q;
  assign cpu_enable  = cpu_enable_q;
  assign busy        = busy_q;
  assign drop_cnt    = drop_cnt_q;

`ifdef LOADER_CHECKSUM_EN
  logic        csum_clr;
  logic        csum_add;
  logic [63:0] csum_val;

  // RUN is always legal from IDLE, so no alignment qualification is needed.
  assign csum_clr = xfer && (state_q == ST_IDLE) && (cmd_op == OP_RUN);
  assign csum_add = (state_q == ST_WRITE);
  assign csum_val = (op_q == OP_WR_IMEM) ? {32'd0, wdata_q[31:0]} : wdata_q;

  loader_checksum u_checksum (
    .clk     (clk),
    .arst_n  (arst_n),
    .clr     (csum_clr),
    .add_en  (csum_add),
    .add_val (csum_val),
    .sum     (checksum)
  );
`else
  assign checksum = 64'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_loader
// Description : Directed bench for mem_loader. Instance A (RD_LAT=1, DROP_W=8)
//               talks to a small SRAM model; instance B (RD_LAT=3, DROP_W=2)
//               covers counter saturation, longer latency and mid-read reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_loader;
  import loader_pkg::*;

  localparam int LAT_A  = 1;
  localparam int DROP_A = 8;
  localparam int LAT_B  = 3;
  localparam int DROP_B = 2;
  localparam logic [63:0] B_RD_WORD = 64'h0123_4567_89AB_CDEF;

  logic clk;
  logic arst_n;

  // Instance A
  logic              cmd_valid_a, cmd_ready_a, rsp_valid_a, rsp_ready_a;
  logic [2:0]        cmd_op_a;
  logic [63:0]       cmd_addr_a, cmd_wdata_a, rsp_data_a;
  logic [63:0]       addr_a, addr2_a, wdata2_a, rdata2_a, csum_a;
  logic              wen_a, ren_a, wen2_a, ren2_a, cpu_en_a, busy_a;
  logic [31:0]       wdata_a, rdata_a;
  logic [DROP_A-1:0] drop_a;

  // Instance B
  logic              cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b;
  logic [2:0]        cmd_op_b;
  logic [63:0]       cmd_addr_b, cmd_wdata_b, rsp_data_b;
  logic [63:0]       addr_b, addr2_b, wdata2_b, rdata2_b, csum_b;
  logic              wen_b, ren_b, wen2_b, ren2_b, cpu_en_b, busy_b;
  logic [31:0]       wdata_b, rdata_b;
  logic [DROP_B-1:0] drop_b;

  mem_loader #(.RD_LAT(LAT_A), .DROP_W(DROP_A)) dut_a (
    .clk(clk), .arst_n(arst_n),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_op(cmd_op_a),
    .cmd_addr(cmd_addr_a), .cmd_wdata(cmd_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_data(rsp_data_a),
    .addr_ext(addr_a), .wen_ext(wen_a), .ren_ext(ren_a),
    .wdata_ext(wdata_a), .rdata_ext(rdata_a),
    .addr_ext_2(addr2_a), .wen_ext_2(wen2_a), .ren_ext_2(ren2_a),
    .wdata_ext_2(wdata2_a), .rdata_ext_2(rdata2_a),
    .cpu_enable(cpu_en_a), .busy(busy_a), .drop_cnt(drop_a), .checksum(csum_a)
  );

  mem_loader #(.RD_LAT(LAT_B), .DROP_W(DROP_B)) dut_b (
    .clk(clk), .arst_n(arst_n),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op_b),
    .cmd_addr(cmd_addr_b), .cmd_wdata(cmd_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b),
    .addr_ext(addr_b), .wen_ext(wen_b), .ren_ext(ren_b),
    .wdata_ext(wdata_b), .rdata_ext(rdata_b),
    .addr_ext_2(addr2_b), .wen_ext_2(wen2_b), .ren_ext_2(ren2_b),
    .wdata_ext_2(wdata2_b), .rdata_ext_2(rdata2_b),
    .cpu_enable(cpu_en_b), .busy(busy_b), .drop_cnt(drop_b), .checksum(csum_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model for A: read data is valid only in the cycle after ren.
  logic [31:0] sram_i [0:15];
  logic [63:0] sram_d [0:15];
  logic        i_rv, d_rv;
  logic [31:0] i_rd;
  logic [63:0] d_rd;

  always @(posedge clk) begin
    if (wen_a)  sram_i[addr_a[5:2]]  <= wdata_a;
    if (wen2_a) sram_d[addr2_a[6:3]] <= wdata2_a;
    i_rv <= ren_a;
    d_rv <= ren2_a;
    i_rd <= sram_i[addr_a[5:2]];
    d_rd <= sram_d[addr2_a[6:3]];
  end
  assign rdata_a  = i_rv ? i_rd : 32'hBAD0_BAD0;
  assign rdata2_a = d_rv ? d_rd : 64'hBAD0_BAD0_BAD0_BAD0;

  // Latency-3 source for B: constant word valid exactly 3 cycles after ren.
  logic [2:0] pipe_b;
  always @(posedge clk) begin
    if (!arst_n) pipe_b <= 3'b000;
    else         pipe_b <= {pipe_b[1:0], ren2_b};
  end
  assign rdata2_b = pipe_b[2] ? B_RD_WORD : 64'h0;
  assign rdata_b  = 32'h0;

  // Scoreboard and reference state.
  logic [63:0] exp_q [$];
  logic [31:0] ref_i [0:15];
  logic [63:0] ref_d [0:15];
  logic [63:0] exp_sum;
  int          exp_drop_a;
  int          exp_drop_b;
  int          n_checks;
  int          n_errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] csum_model();
`ifdef LOADER_CHECKSUM_EN
    return exp_sum;
`else
    return 64'd0;
`endif
  endfunction

  // Drive one command from a falling edge; returns on the falling edge that
  // follows the accepting rising edge.
  task automatic send_a(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] wd);
    chk("cmd_ready_a_before_send", cmd_ready_a, 1'b1);
    cmd_op_a = op; cmd_addr_a = addr; cmd_wdata_a = wd; cmd_valid_a = 1'b1;
    @(negedge clk);
    cmd_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [2:0] op, input logic [63:0] addr);
    chk("cmd_ready_b_before_send", cmd_ready_b, 1'b1);
    cmd_op_b = op; cmd_addr_b = addr; cmd_wdata_b = 64'd0; cmd_valid_b = 1'b1;
    @(negedge clk);
    cmd_valid_b = 1'b0;
  endtask

  task automatic chk_quiet_a(input string tag);
    chk(tag, {wen_a, ren_a, wen2_a, ren2_a}, 4'b0000);
  endtask

  // Wait for A's response, compare with the scoreboard head, hold off ready
  // for 'hold' cycles, then complete the handshake.
  task automatic get_rsp_a(input string tag, input int exp_edges, input int hold);
    int          edges;
    logic [63:0] exp;
    edges = 0;
    while (rsp_valid_a !== 1'b1 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    chk({tag, "_latency"}, edges, exp_edges);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_0000_0000_DEAD;
    chk({tag, "_data"}, rsp_data_a, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, rsp_valid_a, 1'b1);
      chk({tag, "_hold_data"}, rsp_data_a, exp);
      chk({tag, "_hold_cmd_ready"}, cmd_ready_a, 1'b0);
    end
    rsp_ready_a = 1'b1;
    @(negedge clk);
    rsp_ready_a = 1'b0;
    chk({tag, "_valid_cleared"}, rsp_valid_a, 1'b0);
    chk({tag, "_back_to_idle"}, cmd_ready_a, 1'b1);
  endtask

  initial begin
    int edges;
    n_checks = 0; n_errors = 0;
    exp_sum = 64'd0; exp_drop_a = 0; exp_drop_b = 0;
    cmd_valid_a = 0; cmd_op_a = 0; cmd_addr_a = 0; cmd_wdata_a = 0; rsp_ready_a = 0;
    cmd_valid_b = 0; cmd_op_b = 0; cmd_addr_b = 0; cmd_wdata_b = 0; rsp_ready_b = 0;
    arst_n = 1'b1;
    #1 arst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cmd_ready", cmd_ready_a, 1'b1);
    chk("rst_rsp_valid", rsp_valid_a, 1'b0);
    chk("rst_cpu_enable", cpu_en_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_drop_cnt", drop_a, 0);
    chk("rst_checksum", csum_a, 64'd0);
    chk_quiet_a("rst_strobes");
    arst_n = 1'b1;
    @(negedge clk);

    // WR_IMEM: single-cycle imem strobe with registered address/data
    send_a(OP_WR_IMEM, 64'h8, 64'h0000_0000_00A0_0093);
    ref_i[2] = 32'h00A0_0093; exp_sum += 64'h00A0_0093;
    chk("wr_imem_wen", {wen_a, ren_a, wen2_a, ren2_a}, 4'b1000);
    chk("wr_imem_addr", addr_a, 64'h8);
    chk("wr_imem_wdata", wdata_a, 32'h00A0_0093);
    chk("wr_imem_busy", busy_a, 1'b1);
    chk("wr_imem_cmd_ready", cmd_ready_a, 1'b0);
    @(negedge clk);
    chk_quiet_a("wr_imem_one_cycle");
    chk("wr_imem_busy_clear", busy_a, 1'b0);

    // WR_DMEM then RD_DMEM with back-pressure
    send_a(OP_WR_DMEM, 64'h10, 64'hDEAD_BEEF_CAFE_F00D);
    ref_d[2] = 64'hDEAD_BEEF_CAFE_F00D; exp_sum += 64'hDEAD_BEEF_CAFE_F00D;
    chk("wr_dmem_wen2", {wen_a, ren_a, wen2_a, ren2_a}, 4'b0010);
    chk("wr_dmem_addr2", addr2_a, 64'h10);
    chk("wr_dmem_wdata2", wdata2_a, 64'hDEAD_BEEF_CAFE_F00D);
    @(negedge clk);
    chk("csum_after_writes", csum_a, csum_model());

    send_a(OP_RD_DMEM, 64'h10, 64'd0);
    exp_q.push_back(ref_d[2]);
    chk("rd_dmem_ren2", {wen_a, ren_a, wen2_a, ren2_a}, 4'b0001);
    chk("rd_dmem_busy", busy_a, 1'b1);
    get_rsp_a("rd_dmem", LAT_A + 1, 3);

    // RD_IMEM zero-extends; ready held high early completes on first RESP cycle
    rsp_ready_a = 1'b1;
    @(negedge clk);
    chk("early_ready_no_effect", rsp_valid_a, 1'b0);
    send_a(OP_RD_IMEM, 64'h8, 64'd0);
    exp_q.push_back({32'd0, ref_i[2]});
    chk("rd_imem_ren", {wen_a, ren_a, wen2_a, ren2_a}, 4'b0100);
    get_rsp_a("rd_imem", LAT_A + 1, 0);

    // Misaligned and illegal commands are dropped in IDLE
    send_a(OP_RD_IMEM, 64'h6, 64'd0);
    exp_drop_a++;
    chk_quiet_a("drop_misaligned_strobes");
    chk("drop_misaligned_idle", cmd_ready_a, 1'b1);
    send_a(3'd7, 64'h0, 64'd0);
    exp_drop_a++;
    chk_quiet_a("drop_illegal_strobes");
    chk("drop_cnt_two", drop_a, exp_drop_a);
    send_a(OP_WR_DMEM, 64'h4, 64'h1111);
    exp_drop_a++;
    chk_quiet_a("drop_dmem_misaligned_strobes");
    chk("drop_cnt_three", drop_a, exp_drop_a);
    send_a(OP_STOP, 64'h0, 64'd0);
    chk("stop_in_idle_no_drop", drop_a, exp_drop_a);
    chk("stop_in_idle_enable", cpu_en_a, 1'b0);

    // RUN / STOP
    send_a(OP_RUN, 64'h0, 64'd0);
    exp_sum = 64'd0;
    chk("run_cpu_enable", cpu_en_a, 1'b1);
    chk("run_busy", busy_a, 1'b0);
    chk("run_csum_cleared", csum_a, csum_model());
    send_a(OP_WR_DMEM, 64'h8, 64'h5555);
    exp_drop_a++;
    chk_quiet_a("run_write_blocked");
    chk("run_drop_cnt", drop_a, exp_drop_a);
    chk("run_still_enabled", cpu_en_a, 1'b1);
    send_a(OP_STOP, 64'h0, 64'd0);
    chk("stop_cpu_enable", cpu_en_a, 1'b0);

    // Writes after STOP perform normally; checksum wraps
    send_a(OP_WR_IMEM, 64'h0, 64'h0000_0000_FFFF_FFFF);
    ref_i[0] = 32'hFFFF_FFFF; exp_sum += 64'h0000_0000_FFFF_FFFF;
    chk("post_stop_wen", {wen_a, ren_a, wen2_a, ren2_a}, 4'b1000);
    @(negedge clk);
    send_a(OP_WR_DMEM, 64'h8, 64'hFFFF_FFFF_FFFF_FFFF);
    ref_d[1] = 64'hFFFF_FFFF_FFFF_FFFF; exp_sum += 64'hFFFF_FFFF_FFFF_FFFF;
    chk("post_stop_wen2", {wen_a, ren_a, wen2_a, ren2_a}, 4'b0010);
    @(negedge clk);
    chk("csum_wrap", csum_a, csum_model());
`ifdef LOADER_CHECKSUM_EN
    chk("csum_wrap_value", csum_a, 64'h0000_0000_FFFF_FFFE);
`endif
    send_a(OP_RD_IMEM, 64'h0, 64'd0);
    exp_q.push_back({32'd0, ref_i[0]});
    get_rsp_a("rd_imem_ones", LAT_A + 1, 1);

    // Instance B: drop counter saturates at 3 with DROP_W=2
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: send_b(OP_RD_IMEM, 64'h6);
        1: send_b(3'd7, 64'h0);
        2: send_b(3'd6, 64'h0);
        3: send_b(OP_WR_DMEM, 64'h4);
        default: send_b(OP_WR_IMEM, 64'h1);
      endcase
      exp_drop_b = (exp_drop_b == 3) ? 3 : exp_drop_b + 1;
      chk("b_drop_strobes", {wen_b, ren_b, wen2_b, ren2_b}, 4'b0000);
      chk("b_drop_sat", drop_b, exp_drop_b);
    end

    // Instance B: RD_LAT=3 read
    send_b(OP_RD_DMEM, 64'h0);
    chk("b_rd_ren2", ren2_b, 1'b1);
    edges = 0;
    while (rsp_valid_b !== 1'b1 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    chk("b_rd_latency", edges, LAT_B + 1);
    chk("b_rd_data", rsp_data_b, B_RD_WORD);
    rsp_ready_b = 1'b1;
    @(negedge clk);
    rsp_ready_b = 1'b0;
    chk("b_rd_valid_cleared", rsp_valid_b, 1'b0);

    // Reset during RD_WAIT on B while A is running
    send_a(OP_RUN, 64'h0, 64'd0);
    chk("a_run_before_reset", cpu_en_a, 1'b1);
    send_b(OP_RD_DMEM, 64'h8);
    @(negedge clk);
    chk("b_in_rd_wait_busy", busy_b, 1'b1);
    #2 arst_n = 1'b0;
    #1;
    chk("areset_b_busy", busy_b, 1'b0);
    chk("areset_b_strobes", {wen_b, ren_b, wen2_b, ren2_b}, 4'b0000);
    chk("areset_b_rsp_valid", rsp_valid_b, 1'b0);
    chk("areset_b_cmd_ready", cmd_ready_b, 1'b1);
    chk("areset_b_drop_cnt", drop_b, 0);
    chk("areset_a_cpu_enable", cpu_en_a, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_no_rsp", rsp_valid_b, 1'b0);
      chk("post_reset_idle", {cmd_ready_b, busy_b}, 2'b10);
    end
    chk("post_reset_a_idle", {cmd_ready_a, cpu_en_a, drop_a == 0}, 3'b101);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
